// File: rtl/event_enc_pkg.sv
// Shared constants and types for the 8-to-3 event encoder.
package event_enc_pkg;
  localparam int ENC_SIZE_IN  = 8;
  localparam int ENC_SIZE_OUT = 3;

  typedef logic [ENC_SIZE_IN-1:0]  req_vec_t;
  typedef logic [ENC_SIZE_OUT-1:0] enc_idx_t;

  // Lines already high when reset releases must not look like fresh edges.
  localparam req_vec_t REQ_D_RESET = 8'hFF;
endpackage

// File: rtl/rr_pick_8.sv
// Combinational picker: first set bit of an 8-bit map, searching upward from
// a start index with wrap. mode=0 forces the search to start at 0 (fixed priority).
module rr_pick_8
  import event_enc_pkg::*;
(
  input  logic     [ENC_SIZE_IN-1:0] bitmap,
  input  enc_idx_t                   start,
  input  logic                       mode,
  output logic                       found,
  output enc_idx_t                   index,
  output logic     [ENC_SIZE_IN-1:0] grant
);

  enc_idx_t base;
  enc_idx_t pos;

  assign base = mode ? start : '0;

  // Scan from the farthest offset down so the nearest hit is the one kept.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = ENC_SIZE_IN - 1; k >= 0; k--) begin
      pos = base + enc_idx_t'(k);
      if (bitmap[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

  assign grant = found ? (req_vec_t'(1) << index) : '0;

endmodule

// File: rtl/event_encoder_8x3.sv
// Sequential 8-to-3 event encoder: latches rising edges of req as pending
// events and emits one encoded index per valid/ready handshake.
module event_encoder_8x3
  import event_enc_pkg::*;
#(
  parameter int SIZE_IN     = ENC_SIZE_IN,
  parameter int SIZE_OUT    = ENC_SIZE_OUT,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SIZE_IN-1:0]  req,
  input  logic                out_ready,
  input  logic                ovf_clr,
  output logic                out_valid,
  output logic [SIZE_OUT-1:0] out_code,
  output logic [SIZE_IN-1:0]  pending,
  output logic [SIZE_IN-1:0]  overflow
);

  req_vec_t req_d;
  req_vec_t req_edge;
  req_vec_t pick_grant;
  req_vec_t grant_mask;
  enc_idx_t pick_index;
  enc_idx_t rr_ptr;
  logic     pick_found;
  logic     slot_free;
  logic     load;

  assign req_edge = req & ~req_d;

  // Handshake: out_code is consumed on any clk edge where out_valid and
  // out_ready are both high; out_valid/out_code never change while
  // out_valid=1 and out_ready=0, and a consumed slot may reload the same edge.
  assign slot_free  = ~out_valid | out_ready;
  assign load       = slot_free & pick_found;
  assign grant_mask = load ? pick_grant : '0;

  // Selection looks only at registered pending, never at same-cycle edges.
  rr_pick_8 u_pick (
    .bitmap (pending),
    .start  (rr_ptr),
    .mode   (ROUND_ROBIN != 0),
    .found  (pick_found),
    .index  (pick_index),
    .grant  (pick_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d     <= REQ_D_RESET;
      pending   <= '0;
      overflow  <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      rr_ptr    <= '0;
    end else begin
      req_d    <= req;
      // An edge landing on the bit being granted is a new event and keeps it set.
      pending  <= (pending & ~grant_mask) | req_edge;
      overflow <= (ovf_clr ? '0 : overflow) | (req_edge & pending & ~grant_mask);
      if (slot_free) begin
        out_valid <= pick_found;
        if (pick_found) begin
          out_code <= pick_index;
          rr_ptr   <= pick_index + enc_idx_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_event_encoder_8x3.sv
// Self-checking bench for event_encoder_8x3: directed vector table, hand
// sequences for round-robin and async reset, then random traffic vs a model.
module tb_event_encoder_8x3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic       ovf_clr;

  logic       fp_valid, rr_valid;
  logic [2:0] fp_code, rr_code;
  logic [7:0] fp_pend, rr_pend, fp_ovf, rr_ovf;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];

  // reference model state, index 0 = fixed priority, 1 = round robin
  logic [7:0] m_pend[2];
  logic [7:0] m_ovf[2];
  logic       m_valid[2];
  int         m_code[2];
  int         m_ptr[2];
  logic [7:0] m_reqd;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic [2:0] exp_code;
    logic [7:0] exp_pend;
    logic [7:0] exp_ovf;
  } vec_t;

  vec_t vecs[34];

  event_encoder_8x3 #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(fp_valid), .out_code(fp_code), .pending(fp_pend), .overflow(fp_ovf)
  );

  event_encoder_8x3 #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(rr_valid), .out_code(rr_code), .pending(rr_pend), .overflow(rr_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 8'h00;
      m_ovf[d]   = 8'h00;
      m_valid[d] = 1'b0;
      m_code[d]  = 0;
      m_ptr[d]   = 0;
    end
    m_reqd = 8'hFF;
    exp_q.delete();
  endtask

  // One clock of the behavioural rules, using inputs as seen at the edge.
  task automatic model_step();
    logic [7:0] e;
    int         sel;
    int         j;
    logic       free;
    e = req & ~m_reqd;
    for (int d = 0; d < 2; d++) begin
      free = !m_valid[d] || out_ready;
      sel  = -1;
      if (free) begin
        for (int k = 0; k < 8; k++) begin
          j = ((d == 1 ? m_ptr[d] : 0) + k) % 8;
          if (sel < 0 && m_pend[d][j]) sel = j;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (ovf_clr) m_ovf[d][i] = 1'b0;
        if (e[i] && m_pend[d][i] && i != sel) m_ovf[d][i] = 1'b1;
        m_pend[d][i] = (m_pend[d][i] && i != sel) || e[i];
      end
      if (free) begin
        if (sel >= 0) begin
          m_valid[d] = 1'b1;
          m_code[d]  = sel;
          m_ptr[d]   = (sel + 1) % 8;
          if (d == 0) exp_q.push_back(sel[2:0]);
        end else begin
          m_valid[d] = 1'b0;
        end
      end
    end
    m_reqd = req;
  endtask

  task automatic check_model();
    chk("m_fp_valid", 8'(fp_valid), 8'(m_valid[0]));
    chk("m_fp_code",  8'(fp_code),  8'(m_code[0]));
    chk("m_fp_pend",  fp_pend,      m_pend[0]);
    chk("m_fp_ovf",   fp_ovf,       m_ovf[0]);
    chk("m_rr_valid", 8'(rr_valid), 8'(m_valid[1]));
    chk("m_rr_code",  8'(rr_code),  8'(m_code[1]));
    chk("m_rr_pend",  rr_pend,      m_pend[1]);
    chk("m_rr_ovf",   rr_ovf,       m_ovf[1]);
  endtask

  // driver: inputs already applied; advance one edge, then check
  task automatic tick();
    logic       hs;
    logic [2:0] hc;
    logic [2:0] exp_c;
    hs = fp_valid && out_ready;
    hc = fp_code;
    @(posedge clk);
    model_step();
    #1;
    check_model();
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_code", 8'(hc), 8'hFF);
      end else begin
        exp_c = exp_q.pop_front();
        chk("sb_code", 8'(hc), 8'(exp_c));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_fp_valid", 8'(fp_valid), 8'h00);
    chk("rst_fp_code",  8'(fp_code),  8'h00);
    chk("rst_fp_pend",  fp_pend,      8'h00);
    chk("rst_fp_ovf",   fp_ovf,       8'h00);
    chk("rst_rr_valid", 8'(rr_valid), 8'h00);
    chk("rst_rr_pend",  rr_pend,      8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [7:0] r, input logic rdy, input logic clr,
                              input logic v, input logic [2:0] c,
                              input logic [7:0] p, input logic [7:0] o);
    vec_t t;
    t.req = r; t.rdy = rdy; t.clr = clr;
    t.exp_valid = v; t.exp_code = c; t.exp_pend = p; t.exp_ovf = o;
    return t;
  endfunction

  initial begin
    // fixed-priority expectations, one row per clock edge
    for (int i = 0; i < 10; i++) vecs[i] = mk(8'h05, 1, 0, 0, 0, 8'h00, 8'h00);
    vecs[10] = mk(8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
    vecs[11] = mk(8'h40, 1, 0, 0, 0, 8'h40, 8'h00);
    vecs[12] = mk(8'h00, 1, 0, 1, 6, 8'h00, 8'h00);
    vecs[13] = mk(8'h00, 1, 0, 0, 6, 8'h00, 8'h00);
    vecs[14] = mk(8'h8A, 1, 0, 0, 6, 8'h8A, 8'h00);
    vecs[15] = mk(8'h00, 1, 0, 1, 1, 8'h88, 8'h00);
    vecs[16] = mk(8'h00, 1, 0, 1, 3, 8'h80, 8'h00);
    vecs[17] = mk(8'h00, 1, 0, 1, 7, 8'h00, 8'h00);
    vecs[18] = mk(8'h00, 1, 0, 0, 7, 8'h00, 8'h00);
    vecs[19] = mk(8'h04, 0, 0, 0, 7, 8'h04, 8'h00);
    vecs[20] = mk(8'h00, 0, 0, 1, 2, 8'h00, 8'h00);
    vecs[21] = mk(8'h04, 0, 0, 1, 2, 8'h04, 8'h00);
    vecs[22] = mk(8'h00, 0, 0, 1, 2, 8'h04, 8'h00);
    vecs[23] = mk(8'h04, 0, 0, 1, 2, 8'h04, 8'h04);
    vecs[24] = mk(8'h00, 1, 0, 1, 2, 8'h00, 8'h04);
    vecs[25] = mk(8'h00, 1, 0, 0, 2, 8'h00, 8'h04);
    vecs[26] = mk(8'h00, 1, 1, 0, 2, 8'h00, 8'h00);
    vecs[27] = mk(8'h01, 0, 0, 0, 2, 8'h01, 8'h00);
    vecs[28] = mk(8'h00, 0, 0, 1, 0, 8'h00, 8'h00);
    vecs[29] = mk(8'h10, 0, 0, 1, 0, 8'h10, 8'h00);
    vecs[30] = mk(8'h00, 0, 0, 1, 0, 8'h10, 8'h00);
    vecs[31] = mk(8'h10, 1, 0, 1, 4, 8'h10, 8'h00);
    vecs[32] = mk(8'h00, 1, 0, 1, 4, 8'h00, 8'h00);
    vecs[33] = mk(8'h00, 1, 0, 0, 4, 8'h00, 8'h00);

    rst_n = 1'b0; req = 8'h05; out_ready = 1'b1; ovf_clr = 1'b0;
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 34; i++) begin
      req = vecs[i].req; out_ready = vecs[i].rdy; ovf_clr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_valid", i), 8'(fp_valid), 8'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_code", i),  8'(fp_code),  8'(vecs[i].exp_code));
      chk($sformatf("vec%0d_pend", i),  fp_pend,      vecs[i].exp_pend);
      chk($sformatf("vec%0d_ovf", i),   fp_ovf,       vecs[i].exp_ovf);
    end
    ovf_clr = 1'b0;

    // round robin: emit 3 so the pointer sits at 4, then edges on 1,3,7
    req = 8'h00; out_ready = 1'b1;
    do_reset();
    tick();
    req = 8'h08; tick();
    req = 8'h00; tick();
    chk("rr_first_valid", 8'(rr_valid), 8'h01);
    chk("rr_first_code",  8'(rr_code),  8'd3);
    tick();
    req = 8'h8A; tick();
    req = 8'h00; tick();
    chk("rr_seq0", 8'(rr_code), 8'd7);
    tick();
    chk("rr_seq1", 8'(rr_code), 8'd1);
    tick();
    chk("rr_seq2", 8'(rr_code), 8'd3);
    chk("rr_seq2_valid", 8'(rr_valid), 8'h01);
    tick();
    chk("rr_seq_done", 8'(rr_valid), 8'h00);

    // async reset in the middle of a stalled burst
    out_ready = 1'b0;
    req = 8'h01; tick();
    req = 8'h00; tick();
    req = 8'hF0; tick();
    chk("burst_pend", fp_pend, 8'hF0);
    chk("burst_valid", 8'(fp_valid), 8'h01);
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) req = 8'h00;
      tick();
      chk("post_rst_valid", 8'(fp_valid), 8'h00);
    end

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      req       = req ^ (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_encoder_8x3.md
Name: event_encoder_8x3

Overview:
- Sequential 8-to-3 event encoder; the inverse direction of the 3x8 decoder.
- Watches 8 request lines and latches each rising edge as a pending event.
- Emits the 3-bit index of one pending event per valid/ready handshake, using fixed-priority or round-robin order.
- Sits between raw request/button lines and consumers that expect an encoded index stream, such as FSMs or the display path.

Parameters:
- SIZE_IN, 8, number of request lines (fixed at 8 for this block).
- SIZE_OUT, 3, width of the encoded index (log2 of SIZE_IN).
- ROUND_ROBIN, 0, selection order: 0 = lowest pending index first; 1 = round-robin starting one above the last emitted index.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  level request lines, synchronous to clk; a 0->1 transition is one event.
- out_ready  input  1  consumer accepts out_code when high together with out_valid.
- ovf_clr  input  1  synchronous clear of all overflow bits.
- out_valid  output  1  out_code holds an unconsumed event.
- out_code  output  3  encoded index of the emitted event.
- pending  output  8  registered pending-event bitmap.
- overflow  output  8  sticky per-line overflow flags.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_code=3'd0, pending=8'h00, overflow=8'h00, round-robin pointer=3'd0, req_d=8'hFF. Because req_d resets high, lines already high at reset release produce no event.
- Edge detect, each clk: edge = req & ~req_d; then req_d <= req.
- Pending update:
  - pending_next = (pending & ~grant_mask) | edge.
  - grant_mask is the one-hot of the index loaded this cycle, or 0 if nothing was loaded.
  - If an edge and a grant hit the same bit in the same cycle, the bit stays set; the new edge counts as a new event.
- Overflow: an edge on a bit that is pending and not granted this cycle sets overflow[i]. That event is dropped. ovf_clr=1 clears every flag, but a simultaneous new overflow on bit i wins for that bit.
- Output slot is free when out_valid=0 or (out_valid & out_ready).
  - If the slot is free and pending != 0: load out_code = selected index, set out_valid=1, clear that pending bit, and set pointer = selected+1 (mod 8, wrap 7->0).
  - If the slot is free and pending == 0: out_valid <= 0; out_code holds its last value.
  - If out_valid=1 and out_ready=0: out_code and out_valid hold; pending keeps accumulating.
- Selection: ROUND_ROBIN=0 picks the lowest set bit of pending. ROUND_ROBIN=1 picks the first set bit searching pointer, pointer+1, ... with wrap. The pointer is unused when ROUND_ROBIN=0.
- Selection uses the registered pending, not same-cycle edges.
- Latency: req rises before edge k, so pending[i]=1 after edge k and out_valid=1 with out_code=i after edge k+1 (2 cycles), provided the slot is free.
- Throughput: one event per cycle while out_ready=1 held high (back-to-back).
- Reset mid-operation: all pending and in-flight events are discarded with no partial output.

Decomposition:
- Shared package event_enc_pkg: constants ENC_SIZE_IN=8, ENC_SIZE_OUT=3, REQ_D_RESET=8'hFF.
- One sub-module, rr_pick_8 (combinational).
  - Inputs: 8-bit bitmap, 3-bit start index, mode.
  - Outputs: found, 3-bit index, 8-bit one-hot grant.
  - Fixed priority is start=0.
- Top level holds the edge detect, pending/overflow registers, output register and pointer.

Test Plan:
- Reset release with req=8'h05 held high -> no event; out_valid stays 0 for 10 cycles; pending=8'h00.
- Single pulse on req[6] with out_ready=1 -> out_valid=1 and out_code=3'd6 exactly 2 cycles after the rising edge, for 1 cycle; pending returns to 8'h00.
- Simultaneous edges on req=8'b1000_1010 with out_ready=1, ROUND_ROBIN=0 -> codes 1,3,7 on three consecutive cycles.
- Same stimulus with ROUND_ROBIN=1 and pointer=4 (after emitting 3) -> codes 7,1,3.
- out_ready=0 while out_code=2 is valid; pulse req[2] twice -> first re-edge sets pending[2], second sets overflow[2]=1; out_code stays 2 until out_ready=1, then 2 is emitted once more; ovf_clr clears overflow to 8'h00.
- Assert rst_n=0 mid-burst with pending=8'hF0 and out_valid=1 -> all outputs go to their reset values immediately (async, before the next clk); no codes after release.
